// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory/address unit and its fetch sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } fetchState_e;

  localparam logic [7:0] DEFAULT_STACK_PAGE = 8'hFF;
  localparam logic [7:0] DEFAULT_IO_PAGE    = 8'hFE;

  // Bit positions inside the sticky stack fault vector
  localparam int FAULT_OVERFLOW  = 0;
  localparam int FAULT_UNDERFLOW = 1;

endpackage

// File: rtl/instr_fetch_seq.sv
// Multi-byte instruction fetch sequencer: reads one ROM byte per cycle at PC
// and asks the owner of PC to advance it after every byte.
module instr_fetch_seq
  import mem_pkg::*;
#(
  parameter int INSTR_BYTES = 3
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [7:0]                     i_romByte,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_pcInc,
  output logic [7:0]                     o_instrCode,
  output logic [(INSTR_BYTES-1)*8-1:0]   o_instrImm
);

  localparam int CNT_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(INSTR_BYTES - 1);

  fetchState_e      stateReg, stateNext;
  logic [CNT_W-1:0] byteCntReg, byteCntNext;
  logic [7:0]       codeReg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stateReg   <= ST_IDLE;
      byteCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      byteCntReg <= byteCntNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    byteCntNext = byteCntReg;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_pcInc     = 1'b0;
    case (stateReg)
      ST_IDLE: begin
        if (i_start) begin
          stateNext   = ST_FETCH;
          byteCntNext = '0;
        end
      end
      ST_FETCH: begin
        o_busy  = 1'b1;
        o_pcInc = 1'b1;
        if (byteCntReg == LAST_BYTE) stateNext = ST_DONE;
        else byteCntNext = byteCntReg + 1'b1;
      end
      ST_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) codeReg <= '0;
    else if (stateReg == ST_FETCH && byteCntReg == '0) codeReg <= i_romByte;
  end

  assign o_instrCode = codeReg;

  // Immediate byte gi arrives at count gi+1; byte 1 lands in the LSB
  genvar gi;
  generate
    for (gi = 0; gi < INSTR_BYTES - 1; gi++) begin : gImm
      logic [7:0] byteReg;
      always_ff @(posedge i_clk) begin
        if (i_reset) byteReg <= '0;
        else if (stateReg == ST_FETCH && byteCntReg == CNT_W'(gi + 1)) byteReg <= i_romByte;
      end
      assign o_instrImm[gi*8 +: 8] = byteReg;
    end
  endgenerate

endmodule

// File: rtl/mem_address_unit.sv
// CPU memory/address unit: PC, SP, address registers, RAM/IO/stack decode,
// bus drive, breakpoints and the instruction-fetch sequencer.
module mem_address_unit
  import mem_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter int         PC_W        = 16,
  parameter int         SP_W        = 8,
  parameter int         NUM_MAR     = 2,
  parameter int         INSTR_BYTES = 3,
  parameter int         NUM_BP      = 2,
  parameter logic [7:0] STACK_PAGE  = DEFAULT_STACK_PAGE,
  parameter logic [7:0] IO_PAGE     = DEFAULT_IO_PAGE,
  parameter int         MAR_SEL_W   = (NUM_MAR > 1) ? $clog2(NUM_MAR) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [DATA_W-1:0]             i_bus,
  output logic [DATA_W-1:0]             o_bus,
  output logic                          o_busEn,
  input  logic                          i_pcInc,
  input  logic                          i_pcLoad,
  input  logic                          i_pcFromImm,
  input  logic [DATA_W-1:0]             i_bus2,
  input  logic                          i_pcToBus,
  input  logic                          i_immToBus,
  input  logic                          i_spPush,
  input  logic                          i_spPop,
  input  logic                          i_marWe,
  input  logic [MAR_SEL_W-1:0]          i_marSel,
  input  logic                          i_marHi,
  input  logic                          i_addrFromImm,
  input  logic                          i_ramNOE,
  input  logic                          i_ramNWE,
  input  logic [DATA_W-1:0]             i_ramData,
  output logic [PC_W:0]                 o_ramAddress,
  output logic                          o_ramWE,
  output logic                          o_ramCE,
  output logic                          o_ioSelect,
  output logic [7:0]                    o_ioAddress,
  input  logic                          i_fetchStart,
  output logic                          o_fetchBusy,
  output logic                          o_fetchDone,
  output logic [PC_W-1:0]               o_romAddress,
  input  logic [DATA_W-1:0]             i_romData,
  output logic [7:0]                    o_instrCode,
  output logic [(INSTR_BYTES-1)*8-1:0]  o_instrImm,
  input  logic [NUM_BP*PC_W-1:0]        i_bpAddr,
  input  logic [NUM_BP-1:0]             i_bpEnable,
  output logic [NUM_BP-1:0]             o_bpHit,
  output logic [1:0]                    o_spFault
);

  localparam int IMM_W = (INSTR_BYTES - 1) * 8;
  localparam logic [SP_W-1:0] SP_MAX = '1;

  logic [PC_W-1:0]  pcReg;
  logic [SP_W-1:0]  spReg;
  logic [1:0]       spFaultReg;
  logic [PC_W-1:0]  marArr [NUM_MAR];
  logic             fetchPcInc;
  logic [IMM_W-1:0] instrImm;
  logic [PC_W-1:0]  immAddr, busAddr, addrSrc;
  logic [7:0]       addrPage;

  instr_fetch_seq #(
    .INSTR_BYTES(INSTR_BYTES)
  ) uFetch (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_fetchStart),
    .i_romByte  (8'(i_romData)),
    .o_busy     (o_fetchBusy),
    .o_done     (o_fetchDone),
    .o_pcInc    (fetchPcInc),
    .o_instrCode(o_instrCode),
    .o_instrImm (instrImm)
  );

  assign o_instrImm   = instrImm;
  assign immAddr      = PC_W'(instrImm);
  assign busAddr      = PC_W'({i_bus2, i_bus});
  assign o_romAddress = pcReg;

  // The sequencer owns PC while busy; external load/inc are dropped then
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pcReg <= '0;
    end else if (fetchPcInc) begin
      pcReg <= pcReg + 1'b1;
    end else if (!o_fetchBusy) begin
      if (i_pcLoad) pcReg <= i_pcFromImm ? immAddr : busAddr;
      else if (i_pcInc) pcReg <= pcReg + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      spReg      <= '0;
      spFaultReg <= '0;
    end else if (i_spPush && !i_spPop) begin
      spReg <= spReg + 1'b1;
      if (spReg == SP_MAX) spFaultReg[FAULT_OVERFLOW] <= 1'b1;
    end else if (i_spPop && !i_spPush) begin
      spReg <= spReg - 1'b1;
      if (spReg == '0) spFaultReg[FAULT_UNDERFLOW] <= 1'b1;
    end
  end

  assign o_spFault = spFaultReg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MAR; gi++) begin : gMar
      logic [PC_W-1:0] marReg;
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          marReg <= '1;
        end else if (i_marWe && i_marSel == MAR_SEL_W'(gi)) begin
          if (i_marHi) marReg[PC_W-1:8] <= (PC_W-8)'(i_bus);
          else marReg[7:0] <= 8'(i_bus);
        end
      end
      assign marArr[gi] = marReg;
    end
  endgenerate

  assign addrSrc     = i_addrFromImm ? immAddr : marArr[i_marSel];
  assign addrPage    = addrSrc[PC_W-1 -: 8];
  assign o_ioAddress = addrSrc[7:0];

  // Stack page swaps the high byte for SP and sets the stack-select bit
  always_comb begin
    o_ramAddress = {1'b0, addrSrc};
    o_ioSelect   = 1'b0;
    o_ramCE      = 1'b1;
    if (addrPage == STACK_PAGE) begin
      o_ramAddress = {1'b1, 8'(spReg), addrSrc[PC_W-9:0]};
    end else if (addrPage == IO_PAGE) begin
      o_ioSelect = 1'b1;
      o_ramCE    = 1'b0;
    end
  end

  assign o_ramWE = !i_ramNWE && o_ramCE;

  always_comb begin
    o_bus   = '0;
    o_busEn = 1'b1;
    if (!i_ramNOE && o_ramCE) o_bus = i_ramData;
    else if (i_pcToBus) o_bus = DATA_W'(pcReg[7:0]);
    else if (i_immToBus) o_bus = DATA_W'(instrImm[7:0]);
    else o_busEn = 1'b0;
  end

  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : gBp
      logic hitReg;
      always_ff @(posedge i_clk) begin
        if (i_reset) hitReg <= 1'b0;
        else hitReg <= i_bpEnable[gi] && (pcReg == i_bpAddr[gi*PC_W +: PC_W]);
      end
      assign o_bpHit[gi] = hitReg;
    end
  endgenerate

endmodule

// File: tb/tb_mem_address_unit.sv
// Randomised self-checking bench for mem_address_unit against a behavioural model.
module tb_mem_address_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_bus, i_bus2, i_ramData;
  logic [7:0]  o_bus;
  logic        o_busEn;
  logic        i_pcInc, i_pcLoad, i_pcFromImm, i_pcToBus, i_immToBus;
  logic        i_spPush, i_spPop, i_marWe, i_marHi, i_addrFromImm;
  logic [0:0]  i_marSel;
  logic        i_ramNOE, i_ramNWE;
  logic [16:0] o_ramAddress;
  logic        o_ramWE, o_ramCE, o_ioSelect;
  logic [7:0]  o_ioAddress;
  logic        i_fetchStart, o_fetchBusy, o_fetchDone;
  logic [15:0] o_romAddress;
  logic [7:0]  i_romData;
  logic [7:0]  o_instrCode;
  logic [15:0] o_instrImm;
  logic [31:0] i_bpAddr;
  logic [1:0]  i_bpEnable, o_bpHit, o_spFault;

  logic [7:0]  rom [0:65535];
  assign i_romData = rom[o_romAddress];

  int checks = 0;
  int failures = 0;

  // Model state
  logic [15:0] mPc, mImm;
  logic [7:0]  mSp, mCode;
  logic [1:0]  mFault;
  logic [15:0] mMar [2];

  always #5 i_clk = ~i_clk;

  mem_address_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_bus(i_bus), .o_bus(o_bus), .o_busEn(o_busEn),
    .i_pcInc(i_pcInc), .i_pcLoad(i_pcLoad), .i_pcFromImm(i_pcFromImm), .i_bus2(i_bus2),
    .i_pcToBus(i_pcToBus), .i_immToBus(i_immToBus), .i_spPush(i_spPush), .i_spPop(i_spPop),
    .i_marWe(i_marWe), .i_marSel(i_marSel), .i_marHi(i_marHi), .i_addrFromImm(i_addrFromImm),
    .i_ramNOE(i_ramNOE), .i_ramNWE(i_ramNWE), .i_ramData(i_ramData),
    .o_ramAddress(o_ramAddress), .o_ramWE(o_ramWE), .o_ramCE(o_ramCE), .o_ioSelect(o_ioSelect),
    .o_ioAddress(o_ioAddress), .i_fetchStart(i_fetchStart), .o_fetchBusy(o_fetchBusy),
    .o_fetchDone(o_fetchDone), .o_romAddress(o_romAddress), .i_romData(i_romData),
    .o_instrCode(o_instrCode), .o_instrImm(o_instrImm), .i_bpAddr(i_bpAddr),
    .i_bpEnable(i_bpEnable), .o_bpHit(o_bpHit), .o_spFault(o_spFault)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_bus = '0; i_bus2 = '0; i_ramData = '0;
    i_pcInc = 0; i_pcLoad = 0; i_pcFromImm = 0; i_pcToBus = 0; i_immToBus = 0;
    i_spPush = 0; i_spPop = 0; i_marWe = 0; i_marHi = 0; i_marSel = '0;
    i_addrFromImm = 0; i_ramNOE = 1; i_ramNWE = 1; i_fetchStart = 0;
    i_bpAddr = '0; i_bpEnable = '0;
  endtask

  task automatic do_reset();
    i_reset = 1; tick(); i_reset = 0;
    mPc = 0; mSp = 0; mFault = 0; mCode = 0; mImm = 0;
    mMar[0] = 16'hFFFF; mMar[1] = 16'hFFFF;
  endtask

  task automatic write_mar(input logic [0:0] sel, input logic [15:0] val);
    i_marWe = 1; i_marSel = sel;
    i_marHi = 1; i_bus = val[15:8]; tick();
    i_marHi = 0; i_bus = val[7:0]; tick();
    i_marWe = 0;
    mMar[sel] = val;
  endtask

  task automatic sp_op(input bit push, input bit pop);
    i_spPush = push; i_spPop = pop; tick();
    i_spPush = 0; i_spPop = 0;
    if (push && !pop) begin
      if (mSp == 8'hFF) mFault[0] = 1'b1;
      mSp = mSp + 8'd1;
    end else if (pop && !push) begin
      if (mSp == 8'h00) mFault[1] = 1'b1;
      mSp = mSp - 8'd1;
    end
  endtask

  task automatic load_pc(input logic [15:0] addr);
    i_pcLoad = 1; i_pcFromImm = 0; i_bus2 = addr[15:8]; i_bus = addr[7:0];
    tick();
    i_pcLoad = 0;
    mPc = addr;
  endtask

  task automatic fetch_and_check(input bit noisy);
    logic [15:0] a1, a2;
    logic [7:0]  expCode;
    logic [15:0] expImm;
    int n;
    a1 = mPc + 16'd1;
    a2 = mPc + 16'd2;
    expCode = rom[mPc];
    expImm = {rom[a2], rom[a1]};
    i_fetchStart = 1; tick(); i_fetchStart = 0;
    n = 1;
    while (o_fetchDone !== 1'b1 && n < 10) begin
      if (noisy) begin
        i_pcInc = 1'($urandom); i_pcLoad = 1'($urandom);
        i_fetchStart = 1'($urandom); i_bus = 8'($urandom); i_bus2 = 8'($urandom);
      end
      tick(); n++;
    end
    i_pcInc = 0; i_pcLoad = 0; i_fetchStart = 0;
    mPc = mPc + 16'd3; mCode = expCode; mImm = expImm;
    checks++;
    if (n != 4) begin failures++; $display("FAIL fetch_latency: got %0d cycles, want 4", n); end
    checks++;
    if (o_instrCode !== expCode) begin failures++; $display("FAIL fetch_code: got %h want %h", o_instrCode, expCode); end
    checks++;
    if (o_instrImm !== expImm) begin failures++; $display("FAIL fetch_imm: got %h want %h", o_instrImm, expImm); end
    checks++;
    if (o_romAddress !== mPc) begin failures++; $display("FAIL fetch_pc: got %h want %h", o_romAddress, mPc); end
    tick();
    checks++;
    if (o_fetchDone !== 1'b0 || o_fetchBusy !== 1'b0) begin
      failures++; $display("FAIL fetch_end: done=%b busy=%b, want 0 0", o_fetchDone, o_fetchBusy);
    end
    $display("fetch pc=%h code=%h imm=%h noisy=%0d", mPc - 16'd3, expCode, expImm, noisy);
  endtask

  task automatic test_reset();
    i_reset = 1; tick();
    checks++;
    if (o_romAddress !== 16'h0 || o_fetchBusy !== 1'b0 || o_fetchDone !== 1'b0) begin
      failures++; $display("FAIL reset_pc_fsm: pc=%h busy=%b done=%b want 0 0 0", o_romAddress, o_fetchBusy, o_fetchDone);
    end
    checks++;
    if (o_instrCode !== 8'h0 || o_instrImm !== 16'h0 || o_bpHit !== 2'b0 || o_spFault !== 2'b0) begin
      failures++; $display("FAIL reset_regs: code=%h imm=%h bp=%b fault=%b want all 0", o_instrCode, o_instrImm, o_bpHit, o_spFault);
    end
    // MARs reset to all-ones, i.e. stack page with SP=0
    for (int s = 0; s < 2; s++) begin
      i_marSel = 1'(s); #1;
      checks++;
      if (o_ramAddress !== 17'h100FF) begin
        failures++; $display("FAIL reset_mar%0d: ramAddress=%h want 100ff", s, o_ramAddress);
      end
    end
    i_marSel = 0;
    do_reset();
    $display("reset checked");
  endtask

  task automatic test_fetch();
    do_reset();
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56;
    fetch_and_check(0);
    for (int i = 0; i < 6; i++) begin
      load_pc(16'($urandom));
      checks++;
      if (o_romAddress !== mPc) begin failures++; $display("FAIL pc_bus_load: got %h want %h", o_romAddress, mPc); end
      fetch_and_check(1);
    end
  endtask

  task automatic test_pc_load();
    logic [15:0] a;
    a = 16'($urandom);
    load_pc(a);
    rom[a] = 8'($urandom); a = a + 16'd1; rom[a] = 8'h34; a = a + 16'd1; rom[a] = 8'h12;
    fetch_and_check(0);
    i_pcLoad = 1; i_pcInc = 1; i_pcFromImm = 1; i_bus = 8'($urandom); i_bus2 = 8'($urandom);
    tick();
    i_pcLoad = 0; i_pcInc = 0; i_pcFromImm = 0;
    mPc = 16'h1234;
    checks++;
    if (o_romAddress !== 16'h1234) begin failures++; $display("FAIL pc_from_imm: got %h want 1234", o_romAddress); end
    load_pc(16'hFFFF);
    i_pcInc = 1; tick(); i_pcInc = 0;
    mPc = 16'h0000;
    checks++;
    if (o_romAddress !== 16'h0000) begin failures++; $display("FAIL pc_wrap: got %h want 0000", o_romAddress); end
    $display("pc load/inc checked");
  endtask

  task automatic test_address();
    do_reset();
    write_mar(0, 16'hFF10);
    for (int i = 0; i < 5; i++) sp_op(1, 0);
    i_addrFromImm = 0; i_marSel = 0; #1;
    checks++;
    if (o_ramAddress !== 17'h10510 || o_ramCE !== 1'b1 || o_ioSelect !== 1'b0) begin
      failures++; $display("FAIL stack_addr: addr=%h ce=%b io=%b want 10510 1 0", o_ramAddress, o_ramCE, o_ioSelect);
    end
    write_mar(0, 16'hFE10); #1;
    checks++;
    if (o_ioSelect !== 1'b1 || o_ramCE !== 1'b0 || o_ioAddress !== 8'h10) begin
      failures++; $display("FAIL io_select: io=%b ce=%b ioaddr=%h want 1 0 10", o_ioSelect, o_ramCE, o_ioAddress);
    end
    $display("address decode checked");
  endtask

  task automatic test_sp();
    write_mar(0, 16'hFF00);
    sp_op(1, 1);
    #1;
    checks++;
    if (o_ramAddress !== {1'b1, mSp, 8'h00}) begin
      failures++; $display("FAIL sp_push_pop: addr=%h want %h", o_ramAddress, {1'b1, mSp, 8'h00});
    end
    while (mSp != 8'hFF) sp_op(1, 0);
    checks++;
    if (o_ramAddress !== 17'h1FF00 || o_spFault !== 2'b00) begin
      failures++; $display("FAIL sp_max: addr=%h fault=%b want 1ff00 00", o_ramAddress, o_spFault);
    end
    sp_op(1, 0);
    tick(); tick();
    checks++;
    if (o_ramAddress !== 17'h10000 || o_spFault !== 2'b01) begin
      failures++; $display("FAIL sp_overflow: addr=%h fault=%b want 10000 01", o_ramAddress, o_spFault);
    end
    sp_op(0, 1);
    checks++;
    if (o_ramAddress !== 17'h1FF00 || o_spFault !== 2'b11) begin
      failures++; $display("FAIL sp_underflow: addr=%h fault=%b want 1ff00 11", o_ramAddress, o_spFault);
    end
    $display("stack pointer checked sp=%h fault=%b", mSp, mFault);
  endtask

  task automatic test_random();
    logic [15:0] src, val;
    logic [16:0] expAddr;
    logic        expCe, expIo, expEn;
    logic [7:0]  expBus;
    int          pick;
    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 2));
      val = 16'($urandom);
      if (pick == 0) val[15:8] = 8'hFF;
      else if (pick == 1) val[15:8] = 8'hFE;
      write_mar(1'($urandom), val);
      sp_op(1'($urandom), 1'($urandom));
      i_addrFromImm = 1'($urandom); i_marSel = 1'($urandom);
      i_ramNOE = 1'($urandom); i_ramNWE = 1'($urandom);
      i_pcToBus = 1'($urandom); i_immToBus = 1'($urandom); i_ramData = 8'($urandom);
      #1;
      src = i_addrFromImm ? mImm : mMar[i_marSel];
      expCe = 1; expIo = 0;
      if (src[15:8] == 8'hFF) expAddr = 17'h10000 + {1'b0, mSp, 8'h00} + 17'(src[7:0]);
      else begin
        expAddr = 17'(src);
        if (src[15:8] == 8'hFE) begin expCe = 0; expIo = 1; end
      end
      expEn = 1;
      if (!i_ramNOE && expCe) expBus = i_ramData;
      else if (i_pcToBus) expBus = mPc[7:0];
      else if (i_immToBus) expBus = mImm[7:0];
      else begin expBus = 0; expEn = 0; end
      checks++;
      if (o_ramAddress !== expAddr || o_ramCE !== expCe || o_ioSelect !== expIo || o_ioAddress !== src[7:0]) begin
        failures++; $display("FAIL rand_addr[%0d]: addr=%h ce=%b io=%b ioaddr=%h want %h %b %b %h",
                             i, o_ramAddress, o_ramCE, o_ioSelect, o_ioAddress, expAddr, expCe, expIo, src[7:0]);
      end
      checks++;
      if (o_ramWE !== (!i_ramNWE && expCe) || o_spFault !== mFault) begin
        failures++; $display("FAIL rand_we_fault[%0d]: we=%b fault=%b want %b %b", i, o_ramWE, o_spFault, !i_ramNWE && expCe, mFault);
      end
      checks++;
      if (o_busEn !== expEn || (expEn && o_bus !== expBus)) begin
        failures++; $display("FAIL rand_bus[%0d]: en=%b bus=%h want %b %h", i, o_busEn, o_bus, expEn, expBus);
      end
      $display("rand[%0d] src=%h sp=%h addr=%h bus=%h", i, src, mSp, expAddr, expBus);
    end
    idle_inputs();
  endtask

  task automatic test_breakpoint();
    logic [15:0] pcBefore;
    do_reset();
    i_bpAddr = {16'h7777, 16'h0003}; i_bpEnable = 2'b11;
    for (int n = 1; n <= 8; n++) begin
      pcBefore = mPc;
      i_fetchStart = (n == 1);
      tick();
      if (n >= 2 && n <= 4) mPc = mPc + 16'd1;
      checks++;
      if (o_bpHit !== {1'b0, pcBefore == 16'h0003} || o_romAddress !== mPc) begin
        failures++; $display("FAIL bp_hit[%0d]: hit=%b pc=%h want %b %h", n, o_bpHit, o_romAddress, {1'b0, pcBefore == 16'h0003}, mPc);
      end
    end
    i_fetchStart = 0;
    i_bpEnable = 2'b00; tick();
    checks++;
    if (o_bpHit !== 2'b00) begin failures++; $display("FAIL bp_disable: hit=%b want 00", o_bpHit); end
    i_bpAddr = '0;
    $display("breakpoints checked");
  endtask

  task automatic test_reset_midfetch();
    bit sawDone;
    do_reset();
    rom[0] = 8'hA5; rom[1] = 8'h5A;
    i_fetchStart = 1; tick(); i_fetchStart = 0;
    tick();
    checks++;
    if (o_romAddress !== 16'h0001 || o_instrCode !== 8'hA5) begin
      failures++; $display("FAIL midfetch_pre: pc=%h code=%h want 0001 a5", o_romAddress, o_instrCode);
    end
    i_reset = 1; tick(); i_reset = 0;
    checks++;
    if (o_fetchBusy !== 1'b0 || o_romAddress !== 16'h0 || o_instrCode !== 8'h0 || o_instrImm !== 16'h0) begin
      failures++; $display("FAIL midfetch_reset: busy=%b pc=%h code=%h imm=%h want 0 0 0 0",
                           o_fetchBusy, o_romAddress, o_instrCode, o_instrImm);
    end
    sawDone = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (o_fetchDone === 1'b1 || o_fetchBusy === 1'b1) sawDone = 1;
    end
    checks++;
    if (sawDone) begin failures++; $display("FAIL midfetch_idle: sequencer active after reset, want idle"); end
    $display("reset mid-fetch checked");
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
    idle_inputs();
    i_reset = 1;
    test_reset();
    test_fetch();
    test_pc_load();
    test_address();
    test_sp();
    test_random();
    test_breakpoint();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
